// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO. One shared adder/subtractor runs
// shift-add multiply or restoring divide, WIDTH iterations per operation.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_op;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [WIDTH-1:0]      r_acc;     // product high half / partial remainder
  logic [WIDTH-1:0]      r_quo;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]      r_mcand;   // multiplicand / divisor magnitude
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic                  r_dbz;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_is_div;
  logic                  w_is_signed;
  logic                  w_no_borrow;
  logic [WIDTH:0]        w_rem_sh;
  logic [WIDTH:0]        w_add_x;
  logic [WIDTH:0]        w_add_y;
  logic                  w_add_sub;
  logic [WIDTH+1:0]      w_sum;
  logic [2*WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]      w_res_hi;
  logic [WIDTH-1:0]      w_res_lo;
  logic                  w_b_zero;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2_if(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign w_is_div    = r_op[1];
  assign w_is_signed = ~r_op[0];
  assign w_b_zero    = (r_b == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; flush overrides everything, including a fresh start
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_PREP;
        S_PREP:  w_next = S_RUN;
        S_RUN:   if (r_cnt == '0) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  w_next = start ? S_PREP : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:                 w_accept = start & ~flush;
      S_PREP, S_RUN, S_FIX:   w_busy   = 1'b1;
      S_DONE: begin
        w_done   = 1'b1;
        w_accept = start & ~flush;
      end
      default: ;
    endcase
  end

  // Shared adder: MUL adds multiplicand (or 0), DIV subtracts divisor from shifted remainder
  always_comb begin
    w_rem_sh = {r_acc, r_quo[WIDTH-1]};
    if (w_is_div) begin
      w_add_x   = w_rem_sh;
      w_add_y   = {1'b0, r_mcand};
      w_add_sub = 1'b1;
    end else begin
      w_add_x   = {1'b0, r_acc};
      w_add_y   = r_quo[0] ? {1'b0, r_mcand} : '0;
      w_add_sub = 1'b0;
    end
    w_sum = {1'b0, w_add_x} + {1'b0, (w_add_sub ? ~w_add_y : w_add_y)}
          + {{(WIDTH+1){1'b0}}, w_add_sub};
  end

  assign w_no_borrow = w_sum[WIDTH+1];

  // Signed fix-up and divide-by-zero override applied in FIX
  always_comb begin
    w_prod = f_neg2_if({r_acc, r_quo}, r_neg_q);
    if (w_is_div) begin
      if (w_b_zero) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = f_neg_if(r_acc, r_neg_r);
        w_res_lo = f_neg_if(r_quo, r_neg_q);
      end
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // Datapath: operand latch, PREP magnitudes, RUN iterations
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          r_op <= op;
          r_a  <= a;
          r_b  <= b;
        end
      end
      S_PREP: begin
        r_acc   <= '0;
        r_cnt   <= CNT_W'(WIDTH-1);
        r_neg_q <= w_is_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        r_neg_r <= w_is_signed & r_a[WIDTH-1];
        if (w_is_div) begin
          r_quo   <= f_abs(r_a, w_is_signed);
          r_mcand <= f_abs(r_b, w_is_signed);
        end else begin
          r_mcand <= f_abs(r_a, w_is_signed);
          r_quo   <= f_abs(r_b, w_is_signed);
        end
      end
      S_RUN: begin
        r_cnt <= r_cnt - 1'b1;
        if (w_is_div) begin
          r_acc <= w_no_borrow ? w_sum[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_no_borrow};
        end else begin
          r_acc <= w_sum[WIDTH:1];
          r_quo <= {w_sum[0], r_quo[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  // Architectural HI/LO and status; MTHI/MTLO only when not busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else begin
      if (r_state == S_FIX) begin
        if (!flush) begin
          r_hi  <= w_res_hi;
          r_lo  <= w_res_lo;
          r_dbz <= w_is_div & w_b_zero;
        end
      end else if (!w_busy) begin
        if (wr_hi) r_hi <= wr_data;
        if (wr_lo) r_lo <= wr_data;
        if (w_accept) r_dbz <= 1'b0;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=32): latency, results, flush, reset, MTHI/MTLO.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle cyc of an op; walks to the done cycle and checks latency and results.
  task automatic wait_check(input int cyc, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input logic edbz, input string tag);
    int lat;
    logic busy_ok;
    lat     = cyc;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 35);
    chk({tag, "_busy_run"}, busy_ok, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       input string tag);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    wait_check(1, ehi, elo, edbz, tag);
  endtask

  initial begin
    int   lat;
    logic seen_done;
    logic busy_seen;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    tick(); tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    #2 reset_n = 1'b1;
    tick();

    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_neg");
    tick();
    chk("done_pulse", done, 0);
    do_op(2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, "multu");
    do_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, "divu_b2b");
    tick();
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
    tick();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");
    tick();
    do_op(2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "divu_zero");
    tick();
    chk("dbz_hold", div_by_zero, 1);

    // start and wr_lo while busy are ignored
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    chk("dbz_clear", div_by_zero, 0);
    tick(); tick(); tick();
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
    tick();
    start = 1'b0; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_lo = 1'b0;
    chk("wr_lo_busy", lo, 32'hFFFF_FFFF);
    wait_check(6, 32'd0, 32'd12, 1'b0, "start_busy");
    tick();

    // flush mid-MULT at cycle 10
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("pre_flush_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    seen_done = 1'b0;
    busy_seen = 1'b0;
    repeat (40) begin
      if (done) seen_done = 1'b1;
      if (busy) busy_seen = 1'b1;
      tick();
    end
    chk("flush_no_done", seen_done, 0);
    chk("flush_no_busy", busy_seen, 0);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'd12);

    // flush beats start
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 0);
    tick();
    chk("flush_start_busy2", busy, 0);

    // MTHI / MTLO in IDLE
    wr_hi = 1'b1; wr_data = 32'hA5A5_A5A5;
    tick();
    wr_hi = 1'b0;
    chk("mthi", hi, 32'hA5A5_A5A5);
    wr_lo = 1'b1; wr_data = 32'h5A5A_5A5A;
    tick();
    wr_lo = 1'b0;
    chk("mtlo", lo, 32'h5A5A_5A5A);

    // write in DONE lands after the result
    do_op(2'b01, 32'd10, 32'd10, 32'd0, 32'd100, 1'b0, "multu_10");
    wr_lo = 1'b1; wr_data = 32'h0000_0055;
    tick();
    wr_lo = 1'b0;
    chk("done_wr_lo", lo, 32'h55);
    chk("done_wr_hi_keep", hi, 32'd0);

    // same-cycle start + MTHI in IDLE
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4; wr_hi = 1'b1; wr_data = 32'h77;
    tick();
    start = 1'b0; wr_hi = 1'b0;
    chk("start_wr_hi", hi, 32'h77);
    chk("start_wr_busy", busy, 1);
    wait_check(1, 32'd1, 32'd2, 1'b0, "divu_9_4");
    tick();

    // async reset mid-DIV at cycle 20
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
